// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. Two WIDTH-bit operands are loaded on a start
//   strobe and processed one bit per clock, LSB first. The arithmetic cell is
//   a 1-bit full adder (add mode) or a 1-bit full subtractor (sub mode).
//   The carry/borrow is held in a flip-flop between bits.
//   The full result and the final carry/borrow appear together with a
//   one-cycle done pulse.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   start  in   request, sampled only while idle
//   mode   in   0 = add (a+b), 1 = subtract (a-b); latched with start
//   a      in   operand A (minuend in sub mode); latched with start
//   b      in   operand B (subtrahend in sub mode); latched with start
//   busy   out  high while an operation is in progress (exactly WIDTH cycles)
//   done   out  one-cycle pulse when result/flag have just been updated
//   result out  sum or difference modulo 2^WIDTH
//   flag   out  final carry-out (add) or final borrow-out (sub)
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    // The counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_mode;
    logic             r_cb;
    logic             r_done;
    logic             r_flag;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_bit;
    logic             w_cb_next;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_a_shifted;
    logic [WIDTH-1:0] w_b_shifted;
    logic [WIDTH-1:0] w_res_shifted;

    // -----------------------------------------------------------------------
    // Arithmetic cell: full adder or full subtractor on the operand LSBs.
    // -----------------------------------------------------------------------
    assign w_ai = r_a_sh[0];
    assign w_bi = r_b_sh[0];

    always_comb begin
        w_bit     = w_ai ^ w_bi ^ r_cb;
        w_cb_next = 1'b0;
        if (r_mode) begin
            // Borrow out: a plain 0-1, or equal bits passing an incoming borrow.
            w_cb_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_cb);
        end else begin
            w_cb_next = (w_ai & w_bi) | (r_cb & (w_ai ^ w_bi));
        end
    end

    // -----------------------------------------------------------------------
    // Shift networks. Operands move right (zero fill at the top). The new
    // result bit enters at the MSB. After WIDTH steps, bit 0 of the result
    // holds the first bit computed.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign w_a_shifted[gi]   = 1'b0;
                assign w_b_shifted[gi]   = 1'b0;
                assign w_res_shifted[gi] = w_bit;
            end else begin : g_low
                assign w_a_shifted[gi]   = r_a_sh[gi+1];
                assign w_b_shifted[gi]   = r_b_sh[gi+1];
                assign w_res_shifted[gi] = r_res_sh[gi+1];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control: next state and per-cycle strobes.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_result <= '0;
            r_mode   <= 1'b0;
            r_cb     <= 1'b0;
            r_done   <= 1'b0;
            r_flag   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;

            if (w_load) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_mode   <= mode;
                r_cb     <= 1'b0;
                r_cnt    <= '0;
                r_res_sh <= '0;
            end else if (w_step) begin
                r_a_sh   <= w_a_shifted;
                r_b_sh   <= w_b_shifted;
                r_res_sh <= w_res_shifted;
                r_cb     <= w_cb_next;
                r_cnt    <= r_cnt + CW'(1);
            end

            // Publish only complete results. This includes the bit being
            // processed on the final step.
            if (w_last) begin
                r_result <= w_res_shifted;
                r_flag   <= w_cb_next;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = r_done;
    assign result = r_result;
    assign flag   = r_flag;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor; processes one bit per clock, LSB first.
- Its arithmetic cell is a 1-bit full adder (add mode) or 1-bit full subtractor (sub mode, difference/borrow), with the carry/borrow held in a flip-flop between bits.
- Loads two WIDTH-bit operands on a start strobe, returns the WIDTH-bit result plus a carry/borrow flag, with a one-cycle done pulse.
- Serves as the small sequential arithmetic unit built from the team's combinational add/subtract cells.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start.
- a  input  WIDTH  operand A (minuend in sub mode); latched with start.
- b  input  WIDTH  operand B (subtrahend in sub mode); latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result/flag are updated.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- flag  output  1  final carry-out (add) or final borrow-out (sub).

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state: state=IDLE, busy=0, done=0, result=0, flag=0, bit counter=0, carry/borrow FF=0, internal shift registers=0.
- Reset mid-operation aborts the operation; no done pulse, and result/flag read 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at edge E:
  - latch a, b, mode into shift registers;
  - clear carry/borrow FF and counter;
  - go to RUN (busy=1 after E).
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each edge: process bit i=counter using the LSBs of the shift registers and the FF.
  - Add: s = ai^bi^c; c' = ai&bi | c&(ai^bi).
  - Sub: d = ai^bi^bw; bw' = (~ai&bi) | (~(ai^bi)&bw).
  - Shift the result bit into the MSB of the result shift register; shift operands right; counter+1.
- Completion, on the edge processing bit WIDTH-1 (edge E+WIDTH):
  - result <= full result shift register (with this last bit);
  - flag <= final c'/bw';
  - done <= 1; state -> IDLE; busy <= 0.
- Latency: done is high in the cycle after edge E+WIDTH, exactly one cycle; busy is high for exactly WIDTH cycles.
- result and flag update only at completion and hold until the next completion or reset. No partial values are visible.
- start while busy=1 is ignored; no queuing. Operand changes while busy have no effect.
- start asserted in the done cycle is accepted, because the state is IDLE; back-to-back operations are therefore every WIDTH+1 cycles.
- mode changes during RUN are ignored.
- Flag meaning:
  - Add: unsigned overflow.
  - Sub: flag=1 iff a<b unsigned; result is then two's complement wrap.
- WIDTH=1 degenerates to one RUN cycle. Result/flag then equal the 1-bit full adder or full subtractor outputs with zero carry-in.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, result=0x00, flag=0 throughout.
- WIDTH=8, add, a=0x3C, b=0x5A, start 1 cycle -> busy high 8 cycles; done pulse 1 cycle later: result=0x96, flag=0. Then add a=0xFF, b=0x01 -> result=0x00, flag=1.
- WIDTH=8, sub, a=0x05, b=0x03 -> result=0x02, flag=0. Sub a=0x03, b=0x05 -> result=0xFE, flag=1. Sub a=0x80, b=0x80 -> result=0x00, flag=0.
- WIDTH=1, all four (a,b) pairs in both modes, compared against the full-adder/full-subtractor truth tables with zero carry-in. Sub (0,1) -> result=1, flag=1; add (1,1) -> result=0, flag=1.
- WIDTH=8, start add 0x10+0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 of RUN -> ignored. Result=0x30 at done; busy length stays 8 cycles.
- Assert rst at cycle 4 of RUN -> next cycle busy=0, result=0, flag=0, no done pulse. A fresh start then completes normally: 0x07-0x01 -> result=0x06, flag=0.
- Start held high continuously with changing operands -> an operation every 9 cycles; each done reflects the operands present at its accepting edge.
